// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard/stall controller: FSM states, forwarding selects
// and the bundle of stage enables/flushes.
package hazard_pkg;

    typedef logic [1:0] state_t;

    localparam state_t StRun     = 2'd0;
    localparam state_t StLdStall = 2'd1;
    localparam state_t StFlush   = 2'd2;
    localparam state_t StMemWait = 2'd3;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_exe_en;
        logic exe_mem_en;
        logic flush_if_id;
        logic flush_id_exe;
    } ctl_t;

    localparam ctl_t CTL_RUN    = 6'b1111_00;
    localparam ctl_t CTL_BUBBLE = 6'b0011_01;
    localparam ctl_t CTL_FLUSH  = 6'b1111_11;
    localparam ctl_t CTL_FREEZE = 6'b0000_00;
    localparam ctl_t CTL_RESET  = 6'b0000_11;

endpackage

// File: rtl/fwd_sel.sv
// Forwarding select for one EXE source operand; the MEM-stage producer is younger than WB, so it wins.
module fwd_sel
    import hazard_pkg::*;
#(
    parameter int unsigned REG_W    = 4,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic [REG_W-1:0] src_i,
    input  logic [REG_W-1:0] rd_mem_i,
    input  logic             mem_wr_i,
    input  logic [REG_W-1:0] rd_wb_i,
    input  logic             wb_wr_i,
    output logic [1:0]       fwd_o
);

    logic src_ok;

    always_comb begin
        src_ok = (ZERO_REG == 0) || (src_i != '0);
        fwd_o  = FWD_RF;
        if (src_ok && mem_wr_i && (rd_mem_i == src_i)) begin
            fwd_o = FWD_MEM;
        end else if (src_ok && wb_wr_i && (rd_wb_i == src_i)) begin
            fwd_o = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline control around REG_EXE: load-use bubbles, branch flushes, memory-wait freezes,
// operand forwarding selects and a saturating stall-cycle counter.
module hazard_stall_unit
    import hazard_pkg::*;
#(
    parameter int unsigned REG_W        = 4,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned ZERO_REG     = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] i_Ra_id,
    input  logic [REG_W-1:0] i_Rb_id,
    input  logic             i_id_valid,
    input  logic [REG_W-1:0] i_Ra_exe,
    input  logic [REG_W-1:0] i_Rb_exe,
    input  logic [REG_W-1:0] i_rd_exe,
    input  logic             i_exe_load,
    input  logic [REG_W-1:0] i_rd_mem,
    input  logic [REG_W-1:0] i_rd_wb,
    input  logic             i_mem_wr,
    input  logic             i_wb_wr,
    input  logic             i_branch_taken,
    input  logic             i_mem_busy,
    input  logic             i_cnt_clr,
    output logic             o_pc_en,
    output logic             o_if_id_en,
    output logic             o_id_exe_en,
    output logic             o_exe_mem_en,
    output logic             o_flush_if_id,
    output logic             o_flush_id_exe,
    output logic [1:0]       o_fwdA,
    output logic [1:0]       o_fwdB,
    output logic [CNT_W-1:0] o_stall_cnt
);

    localparam int unsigned FC_W = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;

    state_t          state_q, state_d;
    logic [FC_W-1:0] fcnt_q, fcnt_d;
    logic [CNT_W-1:0] cnt_q;

    logic            hz;
    ctl_t            run_ctl, ctl;
    state_t          run_next;
    logic [FC_W-1:0] run_fcnt;
    logic [1:0]      fwd_a, fwd_b;

    // Decision taken in RUN; LDSTALL and an exiting MEMWAIT reuse it unchanged.
    always_comb begin
        hz = i_id_valid && i_exe_load && ((ZERO_REG == 0) || (i_rd_exe != '0)) &&
             ((i_rd_exe == i_Ra_id) || (i_rd_exe == i_Rb_id));
        run_ctl  = CTL_RUN;
        run_next = StRun;
        run_fcnt = fcnt_q;
        if (i_branch_taken) begin
            run_ctl = CTL_FLUSH;
            if (FLUSH_CYCLES > 1) begin
                run_next = StFlush;
                run_fcnt = FC_W'(FLUSH_CYCLES - 2);
            end
        end else if (i_mem_busy) begin
            run_ctl  = CTL_FREEZE;
            run_next = StMemWait;
        end else if (hz) begin
            run_ctl  = CTL_BUBBLE;
            run_next = StLdStall;
        end
    end

    always_comb begin
        ctl     = run_ctl;
        state_d = run_next;
        fcnt_d  = run_fcnt;
        case (state_q)
            StRun, StLdStall: ;
            StFlush: begin
                // Only NOPs sit in EXE here, so any branch indication is stale.
                ctl = CTL_FLUSH;
                if (fcnt_q == '0) begin
                    state_d = StRun;
                    fcnt_d  = fcnt_q;
                end else begin
                    state_d = StFlush;
                    fcnt_d  = fcnt_q - FC_W'(1);
                end
            end
            StMemWait: begin
                if (i_mem_busy) begin
                    ctl     = CTL_FREEZE;
                    state_d = StMemWait;
                    fcnt_d  = fcnt_q;
                end
            end
            default: state_d = StRun;
        endcase
        if (!rst_n) begin
            ctl = CTL_RESET;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StRun;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || i_cnt_clr) begin
            cnt_q <= '0;
        end else if (!ctl.pc_en && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    fwd_sel #(
        .REG_W    (REG_W),
        .ZERO_REG (ZERO_REG)
    ) u_fwd_a (
        .src_i    (i_Ra_exe),
        .rd_mem_i (i_rd_mem),
        .mem_wr_i (i_mem_wr),
        .rd_wb_i  (i_rd_wb),
        .wb_wr_i  (i_wb_wr),
        .fwd_o    (fwd_a)
    );

    fwd_sel #(
        .REG_W    (REG_W),
        .ZERO_REG (ZERO_REG)
    ) u_fwd_b (
        .src_i    (i_Rb_exe),
        .rd_mem_i (i_rd_mem),
        .mem_wr_i (i_mem_wr),
        .rd_wb_i  (i_rd_wb),
        .wb_wr_i  (i_wb_wr),
        .fwd_o    (fwd_b)
    );

    assign o_pc_en        = ctl.pc_en;
    assign o_if_id_en     = ctl.if_id_en;
    assign o_id_exe_en    = ctl.id_exe_en;
    assign o_exe_mem_en   = ctl.exe_mem_en;
    assign o_flush_if_id  = ctl.flush_if_id;
    assign o_flush_id_exe = ctl.flush_id_exe;
    assign o_fwdA         = rst_n ? fwd_a : FWD_RF;
    assign o_fwdB         = rst_n ? fwd_b : FWD_RF;
    assign o_stall_cnt    = cnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scenario-driven bench for hazard_stall_unit with an expected-result queue and stall-count model.
module tb_hazard_stall_unit;

    localparam logic [9:0] C_RUN   = 10'b1111_00_00_00;
    localparam logic [9:0] C_HZ    = 10'b0011_01_00_00;
    localparam logic [9:0] C_FL    = 10'b1111_11_00_00;
    localparam logic [9:0] C_BUSY  = 10'b0000_00_00_00;
    localparam logic [9:0] C_RST   = 10'b0000_11_00_00;

    typedef struct packed {
        logic [9:0] ctl;
        logic [3:0] cnt;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] ra_id, rb_id, ra_exe, rb_exe, rd_exe, rd_mem, rd_wb;
    logic       id_valid, exe_load, mem_wr, wb_wr, br, busy, clr;
    logic       pc_en, if_id_en, id_exe_en, exe_mem_en, flush_if_id, flush_id_exe;
    logic [1:0] fwd_a, fwd_b;
    logic [3:0] stall_cnt;

    exp_t       exp_q[$];
    string      name_q[$];
    logic [3:0] exp_cnt;
    int         checks = 0;
    int         errors = 0;

    hazard_stall_unit #(
        .REG_W        (4),
        .CNT_W        (4),
        .FLUSH_CYCLES (3),
        .ZERO_REG     (1)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_Ra_id        (ra_id),
        .i_Rb_id        (rb_id),
        .i_id_valid     (id_valid),
        .i_Ra_exe       (ra_exe),
        .i_Rb_exe       (rb_exe),
        .i_rd_exe       (rd_exe),
        .i_exe_load     (exe_load),
        .i_rd_mem       (rd_mem),
        .i_rd_wb        (rd_wb),
        .i_mem_wr       (mem_wr),
        .i_wb_wr        (wb_wr),
        .i_branch_taken (br),
        .i_mem_busy     (busy),
        .i_cnt_clr      (clr),
        .o_pc_en        (pc_en),
        .o_if_id_en     (if_id_en),
        .o_id_exe_en    (id_exe_en),
        .o_exe_mem_en   (exe_mem_en),
        .o_flush_if_id  (flush_if_id),
        .o_flush_id_exe (flush_id_exe),
        .o_fwdA         (fwd_a),
        .o_fwdB         (fwd_b),
        .o_stall_cnt    (stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic idle();
        rst_n = 1'b1; id_valid = 1'b0; exe_load = 1'b0; mem_wr = 1'b0; wb_wr = 1'b0;
        br = 1'b0; busy = 1'b0; clr = 1'b0;
        ra_id = 4'd0; rb_id = 4'd0; ra_exe = 4'd0; rb_exe = 4'd0;
        rd_exe = 4'd0; rd_mem = 4'd0; rd_wb = 4'd0;
    endtask

    // Load r<r> in EXE while ID reads it through operand A (or B when use_b).
    task automatic set_hz(input logic [3:0] r, input logic use_b);
        id_valid = 1'b1; exe_load = 1'b1; rd_exe = r;
        if (use_b) rb_id = r; else ra_id = r;
    endtask

    // Queue the expectation for the current cycle, then advance the stall-count model.
    task automatic push(input logic [9:0] ctl, input string nm);
        exp_t e;
        e.ctl = ctl;
        e.cnt = exp_cnt;
        exp_q.push_back(e);
        name_q.push_back(nm);
        if (!rst_n || clr) exp_cnt = 4'd0;
        else if (!ctl[9] && exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
    endtask

    task automatic test_reset();
        exp_t e; string nm; logic [9:0] got;
        for (int i = 0; i < 3; i++) begin
            idle();
            if (i < 2) begin
                rst_n = 1'b0; br = 1'b1; busy = 1'b1; mem_wr = 1'b1; rd_mem = 4'd5; ra_exe = 4'd5;
                push(C_RST, $sformatf("reset_hold%0d", i));
            end else begin
                push(C_RUN, "reset_release");
            end
            #3;
            e = exp_q.pop_front(); nm = name_q.pop_front();
            got = {pc_en, if_id_en, id_exe_en, exe_mem_en, flush_if_id, flush_id_exe, fwd_a, fwd_b};
            checks++;
            if (got !== e.ctl) begin
                errors++; $display("FAIL %s ctl got %b want %b", nm, got, e.ctl);
            end
            checks++;
            if (stall_cnt !== e.cnt) begin
                errors++; $display("FAIL %s stall_cnt got %0d want %0d", nm, stall_cnt, e.cnt);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        exp_t e; string nm; logic [9:0] got;
        for (int i = 0; i < 6; i++) begin
            idle();
            case (i)
                0: begin set_hz(4'd3, 1'b0); push(C_HZ, "ldu_a_bubble"); end
                1: begin mem_wr = 1'b1; rd_mem = 4'd3; ra_exe = 4'd3;
                         push(10'b1111_00_01_00, "ldu_a_fwd_mem"); end
                2: begin set_hz(4'd7, 1'b1); push(C_HZ, "ldu_b_bubble"); end
                3: push(C_RUN, "ldu_b_resume");
                4: begin set_hz(4'd0, 1'b0); push(C_RUN, "ldu_zero_reg"); end
                default: begin set_hz(4'd6, 1'b0); id_valid = 1'b0;
                               push(C_RUN, "ldu_id_invalid"); end
            endcase
            #3;
            e = exp_q.pop_front(); nm = name_q.pop_front();
            got = {pc_en, if_id_en, id_exe_en, exe_mem_en, flush_if_id, flush_id_exe, fwd_a, fwd_b};
            checks++;
            if (got !== e.ctl) begin
                errors++; $display("FAIL %s ctl got %b want %b", nm, got, e.ctl);
            end
            checks++;
            if (stall_cnt !== e.cnt) begin
                errors++; $display("FAIL %s stall_cnt got %0d want %0d", nm, stall_cnt, e.cnt);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_forwarding();
        exp_t e; string nm; logic [9:0] got;
        for (int i = 0; i < 4; i++) begin
            idle();
            case (i)
                0: begin mem_wr = 1'b1; wb_wr = 1'b1; rd_mem = 4'd5; rd_wb = 4'd5;
                         ra_exe = 4'd5; rb_exe = 4'd5; push(10'b1111_00_01_01, "fwd_mem_wins"); end
                1: begin mem_wr = 1'b1; wb_wr = 1'b1; push(C_RUN, "fwd_zero_reg"); end
                2: begin wb_wr = 1'b1; rd_mem = 4'd5; rd_wb = 4'd5; ra_exe = 4'd5; rb_exe = 4'd6;
                         push(10'b1111_00_10_00, "fwd_wb_only"); end
                default: begin mem_wr = 1'b1; wb_wr = 1'b1; rd_mem = 4'd6; rd_wb = 4'd5;
                               ra_exe = 4'd5; rb_exe = 4'd6; push(10'b1111_00_10_01, "fwd_split"); end
            endcase
            #3;
            e = exp_q.pop_front(); nm = name_q.pop_front();
            got = {pc_en, if_id_en, id_exe_en, exe_mem_en, flush_if_id, flush_id_exe, fwd_a, fwd_b};
            checks++;
            if (got !== e.ctl) begin
                errors++; $display("FAIL %s ctl got %b want %b", nm, got, e.ctl);
            end
            checks++;
            if (stall_cnt !== e.cnt) begin
                errors++; $display("FAIL %s stall_cnt got %0d want %0d", nm, stall_cnt, e.cnt);
            end
            @(posedge clk); #1;
        end
    endtask

    // Three flush cycles per taken branch, then a second branch straight after.
    task automatic test_branch_flush();
        exp_t e; string nm; logic [9:0] got;
        for (int i = 0; i < 8; i++) begin
            idle();
            case (i)
                0: begin br = 1'b1; push(C_FL, "br_taken"); end
                1: begin br = 1'b1; push(C_FL, "br_flush_ignore_br"); end
                2: begin set_hz(4'd2, 1'b0); push(C_FL, "br_flush_ignore_hz"); end
                3: begin br = 1'b1; push(C_FL, "br_back_to_back"); end
                4: push(C_FL, "br2_flush1");
                5: push(C_FL, "br2_flush2");
                6: push(C_RUN, "br2_done");
                default: push(C_RUN, "br2_idle");
            endcase
            #3;
            e = exp_q.pop_front(); nm = name_q.pop_front();
            got = {pc_en, if_id_en, id_exe_en, exe_mem_en, flush_if_id, flush_id_exe, fwd_a, fwd_b};
            checks++;
            if (got !== e.ctl) begin
                errors++; $display("FAIL %s ctl got %b want %b", nm, got, e.ctl);
            end
            checks++;
            if (stall_cnt !== e.cnt) begin
                errors++; $display("FAIL %s stall_cnt got %0d want %0d", nm, stall_cnt, e.cnt);
            end
            @(posedge clk); #1;
        end
    endtask

    // Four busy cycles with a branch held behind them; then a held load-use hazard.
    task automatic test_memwait();
        exp_t e; string nm; logic [9:0] got;
        for (int i = 0; i < 12; i++) begin
            idle();
            case (i)
                0: begin clr = 1'b1; push(C_RUN, "mw_clear"); end
                1: begin busy = 1'b1; push(C_BUSY, "mw_enter"); end
                2, 3, 4: begin busy = 1'b1; br = 1'b1; push(C_BUSY, "mw_hold_br"); end
                5: begin br = 1'b1; push(C_FL, "mw_exit_flush"); end
                6, 7: push(C_FL, "mw_flush_tail");
                8: begin busy = 1'b1; set_hz(4'd4, 1'b0); push(C_BUSY, "mw_busy_over_hz"); end
                9: begin busy = 1'b1; set_hz(4'd4, 1'b0); push(C_BUSY, "mw_hold_hz"); end
                10: begin set_hz(4'd4, 1'b0); push(C_HZ, "mw_exit_hz"); end
                default: push(C_RUN, "mw_resume");
            endcase
            #3;
            e = exp_q.pop_front(); nm = name_q.pop_front();
            got = {pc_en, if_id_en, id_exe_en, exe_mem_en, flush_if_id, flush_id_exe, fwd_a, fwd_b};
            checks++;
            if (got !== e.ctl) begin
                errors++; $display("FAIL %s ctl got %b want %b", nm, got, e.ctl);
            end
            checks++;
            if (stall_cnt !== e.cnt) begin
                errors++; $display("FAIL %s stall_cnt got %0d want %0d", nm, stall_cnt, e.cnt);
            end
            @(posedge clk); #1;
        end
    endtask

    // Saturate the counter, then branch + hazard + busy together.
    task automatic test_priority_saturate();
        exp_t e; string nm; logic [9:0] got;
        for (int i = 0; i < 26; i++) begin
            idle();
            if (i == 0) begin
                clr = 1'b1; push(C_RUN, "sat_clear");
            end else if (i < 20) begin
                busy = 1'b1; push(C_BUSY, $sformatf("sat_busy%0d", i));
            end else begin
                case (i)
                    20: push(C_RUN, "sat_exit");
                    21: begin br = 1'b1; busy = 1'b1; set_hz(4'd9, 1'b1);
                              push(C_FL, "prio_branch_wins"); end
                    22, 23: push(C_FL, "prio_flush_tail");
                    24: begin set_hz(4'd1, 1'b0); push(C_HZ, "sat_hz_stall"); end
                    default: push(C_RUN, "sat_hold");
                endcase
            end
            #3;
            e = exp_q.pop_front(); nm = name_q.pop_front();
            got = {pc_en, if_id_en, id_exe_en, exe_mem_en, flush_if_id, flush_id_exe, fwd_a, fwd_b};
            checks++;
            if (got !== e.ctl) begin
                errors++; $display("FAIL %s ctl got %b want %b", nm, got, e.ctl);
            end
            checks++;
            if (stall_cnt !== e.cnt) begin
                errors++; $display("FAIL %s stall_cnt got %0d want %0d", nm, stall_cnt, e.cnt);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_stall();
        exp_t e; string nm; logic [9:0] got;
        for (int i = 0; i < 6; i++) begin
            idle();
            case (i)
                0: begin set_hz(4'd3, 1'b0); push(C_HZ, "rst_enter_ldstall"); end
                1, 2: begin rst_n = 1'b0; set_hz(4'd3, 1'b0); br = 1'b1;
                            push(C_RST, "rst_mid_ldstall"); end
                3: push(C_RUN, "rst_release_run");
                4: begin set_hz(4'd8, 1'b0); push(C_HZ, "rst_after_hz"); end
                default: push(C_RUN, "rst_after_idle");
            endcase
            #3;
            e = exp_q.pop_front(); nm = name_q.pop_front();
            got = {pc_en, if_id_en, id_exe_en, exe_mem_en, flush_if_id, flush_id_exe, fwd_a, fwd_b};
            checks++;
            if (got !== e.ctl) begin
                errors++; $display("FAIL %s ctl got %b want %b", nm, got, e.ctl);
            end
            checks++;
            if (stall_cnt !== e.cnt) begin
                errors++; $display("FAIL %s stall_cnt got %0d want %0d", nm, stall_cnt, e.cnt);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        @(posedge clk); #1;
        exp_cnt = 4'd0;
        test_reset();
        test_load_use();
        test_forwarding();
        test_branch_flush();
        test_memwait();
        test_priority_saturate();
        test_reset_mid_stall();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain left %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
